// File: rtl/addr_entry_fifo_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// addr_entry_fifo_arbiter_pkg
// Shared definitions for the address-entry FIFO controller/arbiter:
//   - state_e         : drain/flush sequencer states (RUN, DRAIN, DONE)
//   - RST_SYNC_STAGES : depth of the FIFO reset bridge (2 sync flops + 1 hold)
//   - occ_width()     : width of the occupancy counter for a given FIFO depth
// -----------------------------------------------------------------------------
package addr_entry_fifo_arbiter_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int RST_SYNC_STAGES = 3;

    // Occupancy must represent 0..depth inclusive.
    function automatic int occ_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/addr_entry_fifo_arbiter_if.sv
// -----------------------------------------------------------------------------
// addr_entry_fifo_arbiter_if
// Connection between the controller/arbiter and the shared address-entry FIFO.
//   fifo_rst            : synchronous active-high reset into the FIFO
//   fifo_potential_push : FIFO data write enable
//   fifo_push           : FIFO commit
//   fifo_data_in        : entry written into the FIFO
//   fifo_pop            : FIFO dequeue
//   fifo_valid          : FIFO non-empty
//   fifo_full           : FIFO full
//   fifo_data_out       : FIFO head entry
// Modports: master = controller side, slave = FIFO side.
// -----------------------------------------------------------------------------
interface addr_entry_fifo_arbiter_if #(
    parameter type DATA_TYPE = logic
);
    logic     fifo_rst;
    logic     fifo_potential_push;
    logic     fifo_push;
    DATA_TYPE fifo_data_in;
    logic     fifo_pop;
    logic     fifo_valid;
    logic     fifo_full;
    DATA_TYPE fifo_data_out;

    modport master (
        output fifo_rst, fifo_potential_push, fifo_push, fifo_data_in, fifo_pop,
        input  fifo_valid, fifo_full, fifo_data_out
    );

    modport slave (
        input  fifo_rst, fifo_potential_push, fifo_push, fifo_data_in, fifo_pop,
        output fifo_valid, fifo_full, fifo_data_out
    );
endinterface

// File: rtl/addr_entry_fifo_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// addr_entry_rr_picker
// Combinational rotating-priority picker. Searches req_valid starting at
// rr_ptr and wrapping modulo NUM_REQ; the first set bit wins.
//   req_valid : per-producer request bits
//   rr_ptr    : index holding highest priority this cycle (< NUM_REQ)
//   winner    : index of the selected producer (0 when none)
//   onehot    : one-hot of winner, all-zero when none
//   any       : at least one request present
// -----------------------------------------------------------------------------
module addr_entry_rr_picker #(
    parameter  int NUM_REQ = 4,
    localparam int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [PTR_W-1:0]   winner,
    output logic [NUM_REQ-1:0] onehot,
    output logic               any
);

    int idx;

    always_comb begin
        // NOTE: every output gets a default before any conditional assignment,
        // so no path leaves a value held and no latch is inferred.
        winner = '0;
        onehot = '0;
        any    = 1'b0;
        idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!any && req_valid[idx]) begin
                any    = 1'b1;
                winner = PTR_W'(idx);
            end
        end
        onehot[winner] = any;
    end

endmodule

// File: rtl/addr_entry_fifo_arbiter.sv
// -----------------------------------------------------------------------------
// addr_entry_fifo_arbiter
// Controller and round-robin arbiter in front of the shared address-entry FIFO
// (the FIFO itself lives outside this block).
//   clk, rst       : clock; asynchronous active-low reset
//   req_valid/data : NUM_REQ producers offering entries
//   req_ready      : one-hot, entry i committed this cycle
//   fifo           : master side of the FIFO connection (push/pop/reset/status)
//   cons_*         : valid/ready view of the FIFO head for the consumer
//   flush_req      : one-cycle drain request (honoured only in RUN)
//   flush_busy     : drain in progress
//   flush_done     : one-cycle pulse once the FIFO has drained
//   occupancy      : mirrored FIFO entry count
// -----------------------------------------------------------------------------
module addr_entry_fifo_arbiter
    import addr_entry_fifo_arbiter_pkg::*;
#(
    parameter  type DATA_TYPE  = logic,
    parameter  int  NUM_REQ    = 4,
    parameter  int  FIFO_DEPTH = 4,
    localparam int  PTR_W      = $clog2(NUM_REQ),
    localparam int  OCC_W      = occ_width(FIFO_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  DATA_TYPE             req_data [NUM_REQ],
    output logic [NUM_REQ-1:0]   req_ready,
    addr_entry_fifo_arbiter_if.master fifo,
    output logic                 cons_valid,
    output DATA_TYPE             cons_data,
    input  logic                 cons_ready,
    input  logic                 flush_req,
    output logic                 flush_busy,
    output logic                 flush_done,
    output logic [OCC_W-1:0]     occupancy
);

    logic [RST_SYNC_STAGES-1:0] rst_sync_q, rst_sync_d;
    state_e                     state_q, state_d;
    logic [PTR_W-1:0]           rr_ptr_q, rr_ptr_d;
    logic [OCC_W-1:0]           occ_q, occ_d;

    logic                       fifo_rst_int;
    logic                       grant_en;
    logic                       potential_push;
    logic                       push;
    logic                       pop;
    logic [PTR_W-1:0]           winner;
    logic [NUM_REQ-1:0]         winner_oh;
    logic                       pick_any;

    addr_entry_rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr_q),
        .winner    (winner),
        .onehot    (winner_oh),
        .any       (pick_any)
    );

    // The sync chain clears asynchronously with rst, so fifo_rst rises at
    // once; it falls only after the last stage has clocked in a 1.
    assign fifo_rst_int = ~rst_sync_q[RST_SYNC_STAGES-1];

    always_comb begin
        grant_en       = (state_q == RUN) & ~flush_req & ~fifo_rst_int;
        pop            = fifo.fifo_valid & cons_ready & ~fifo_rst_int;
        potential_push = grant_en & pick_any;
        // A full FIFO still accepts when the head leaves in the same cycle.
        push           = potential_push & (~fifo.fifo_full | pop);
    end

    assign fifo.fifo_rst            = fifo_rst_int;
    assign fifo.fifo_potential_push = potential_push;
    assign fifo.fifo_push           = push;
    assign fifo.fifo_pop            = pop;
    assign fifo.fifo_data_in        = fifo_rst_int ? DATA_TYPE'('0) : req_data[winner];
    assign req_ready                = winner_oh & {NUM_REQ{push}};
    assign cons_valid               = fifo.fifo_valid & ~fifo_rst_int;
    assign cons_data                = fifo_rst_int ? DATA_TYPE'('0) : fifo.fifo_data_out;
    assign occupancy                = occ_q;
    assign flush_busy               = (state_q == DRAIN);
    assign flush_done               = (state_q == DONE);

    always_comb begin
        rst_sync_d = {rst_sync_q[RST_SYNC_STAGES-2:0], 1'b1};

        rr_ptr_d = rr_ptr_q;
        if (push) begin
            rr_ptr_d = (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + PTR_W'(1);
        end

        occ_d = occ_q;
        if (push && !pop && (occ_q != OCC_W'(FIFO_DEPTH))) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (pop && !push && (occ_q != '0)) begin
            occ_d = occ_q - OCC_W'(1);
        end

        state_d = state_q;
        unique case (state_q)
            RUN:     if (flush_req) state_d = DRAIN;
            // Wait for the final pop to retire before declaring empty.
            DRAIN:   if ((occ_q == '0) && !pop) state_d = DONE;
            DONE:    state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop regardless of process order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_sync_q <= '0;
            state_q    <= RUN;
            rr_ptr_q   <= '0;
            occ_q      <= '0;
        end else begin
            rst_sync_q <= rst_sync_d;
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            occ_q      <= occ_d;
        end
    end

    a_full_matches_occ: assert property (@(posedge clk) disable iff (fifo_rst_int)
        fifo.fifo_full == (occ_q == OCC_W'(FIFO_DEPTH)));

    a_valid_matches_occ: assert property (@(posedge clk) disable iff (fifo_rst_int)
        fifo.fifo_valid == (occ_q != '0));

    a_ready_onehot0: assert property (@(posedge clk) disable iff (fifo_rst_int)
        $onehot0(req_ready));

    a_push_only_in_run: assert property (@(posedge clk) disable iff (fifo_rst_int)
        fifo.fifo_push |-> (state_q == RUN));

endmodule

// File: tb/tb_addr_entry_fifo_arbiter.sv
// -----------------------------------------------------------------------------
// tb_addr_entry_fifo_arbiter
// Directed bench for addr_entry_fifo_arbiter with a behavioural 4-deep FIFO on
// the slave side, a cycle model of grants/pops/occupancy/state, and a
// scoreboard queue of entries expected at the consumer.
// -----------------------------------------------------------------------------
module tb_addr_entry_fifo_arbiter;
    import addr_entry_fifo_arbiter_pkg::*;

    typedef logic [7:0] data_t;

    localparam int NUM_REQ = 4;
    localparam int DEPTH   = 4;
    localparam int OCC_W   = occ_width(DEPTH);

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [NUM_REQ-1:0] req_valid = '0;
    data_t              req_data [NUM_REQ];
    logic [NUM_REQ-1:0] req_ready;
    logic               cons_valid;
    data_t              cons_data;
    logic               cons_ready = 1'b0;
    logic               flush_req = 1'b0;
    logic               flush_busy;
    logic               flush_done;
    logic [OCC_W-1:0]   occupancy;

    always #5 clk = ~clk;

    addr_entry_fifo_arbiter_if #(.DATA_TYPE(data_t)) fif ();

    addr_entry_fifo_arbiter #(
        .DATA_TYPE  (data_t),
        .NUM_REQ    (NUM_REQ),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .fifo       (fif),
        .cons_valid (cons_valid),
        .cons_data  (cons_data),
        .cons_ready (cons_ready),
        .flush_req  (flush_req),
        .flush_busy (flush_busy),
        .flush_done (flush_done),
        .occupancy  (occupancy)
    );

    // Behavioural FIFO on the slave side of the interface.
    data_t      mem [DEPTH];
    logic [1:0] wr_ptr, rd_ptr;
    logic [2:0] cnt;

    always @(posedge clk) begin
        if (fif.fifo_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (fif.fifo_push) begin
                mem[wr_ptr] <= fif.fifo_data_in;
                wr_ptr      <= wr_ptr + 2'd1;
            end
            if (fif.fifo_pop) rd_ptr <= rd_ptr + 2'd1;
            cnt <= cnt + 3'(fif.fifo_push) - 3'(fif.fifo_pop);
        end
    end

    assign fif.fifo_valid    = (cnt != 3'd0);
    assign fif.fifo_full     = (cnt == 3'd4);
    assign fif.fifo_data_out = mem[rd_ptr];

    // Counters and reference model.
    int     pass_cnt  = 0;
    int     fail_cnt  = 0;
    int     total_cnt = 0;
    int     cyc       = 0;
    state_e m_state   = RUN;
    int     m_rr      = 0;
    int     m_occ     = 0;
    int     rel_cnt   = 0;
    data_t  exp_q [$];

    logic               last_frst, last_push, last_pp, last_pop, last_busy, last_done;
    logic [NUM_REQ-1:0] last_ready;
    logic [OCC_W-1:0]   last_occ;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_data();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_data[i] = data_t'((i << 6) | (cyc & 63));
        end
    endtask

    // One clock: compare at the falling edge, advance the model, return #1
    // after the rising edge so the caller can drive the next cycle's inputs.
    task automatic tick();
        logic               frst, grant_en, found, pp, pop, push;
        int                 win, idx;
        logic [NUM_REQ-1:0] exp_ready;
        logic [13:0]        exp_vec, obs_vec;
        data_t              head;
        @(negedge clk);
        frst     = (rel_cnt < 3);
        grant_en = (m_state == RUN) && !flush_req && !frst;
        found    = 1'b0;
        win      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (m_rr + k) % NUM_REQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        pp        = grant_en && found;
        pop       = !frst && (m_occ != 0) && cons_ready;
        push      = pp && ((m_occ != DEPTH) || pop);
        exp_ready = push ? NUM_REQ'(1 << win) : '0;
        exp_vec   = {frst, exp_ready, push, pp, pop, !frst && (m_occ != 0),
                     m_state == DRAIN, m_state == DONE, 3'(m_occ)};
        obs_vec   = {fif.fifo_rst, req_ready, fif.fifo_push, fif.fifo_potential_push,
                     fif.fifo_pop, cons_valid, flush_busy, flush_done, occupancy};
        check($sformatf("status@%0d", cyc), 32'(obs_vec), 32'(exp_vec));

        last_frst  = fif.fifo_rst;
        last_ready = req_ready;
        last_push  = fif.fifo_push;
        last_pp    = fif.fifo_potential_push;
        last_pop   = fif.fifo_pop;
        last_busy  = flush_busy;
        last_done  = flush_done;
        last_occ   = occupancy;

        if (pop && (exp_q.size() > 0)) begin
            head = exp_q.pop_front();
            check($sformatf("cons_data@%0d", cyc), 32'(cons_data), 32'(head));
        end
        if (push) begin
            check($sformatf("data_in@%0d", cyc), 32'(fif.fifo_data_in), 32'(req_data[win]));
            exp_q.push_back(req_data[win]);
        end

        if (!rst) begin
            m_state = RUN;
            m_rr    = 0;
            m_occ   = 0;
            rel_cnt = 0;
            exp_q.delete();
        end else begin
            case (m_state)
                RUN:     if (flush_req) m_state = DRAIN;
                DRAIN:   if ((m_occ == 0) && !pop) m_state = DONE;
                default: m_state = RUN;
            endcase
            m_occ = m_occ + int'(push) - int'(pop);
            if (push) m_rr = (win + 1) % NUM_REQ;
            if (rel_cnt < 3) rel_cnt++;
        end
        @(posedge clk);
        #1;
        cyc++;
        drive_data();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed no end of test, required finish before 100000");
        $fatal(1);
    end

    initial begin
        logic [NUM_REQ-1:0] fair_seq [4];
        logic [2:0]         drain_occ [4];
        logic [3:0]         drain_busy, drain_done;
        fair_seq   = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        drain_occ  = '{3'd2, 3'd1, 3'd0, 3'd0};
        drain_busy = 4'b0111;   // bit k = step k
        drain_done = 4'b1000;

        drive_data();
        rst        = 1'b0;
        req_valid  = 4'b1111;
        cons_ready = 1'b1;
        flush_req  = 1'b0;
        tick();
        tick();

        // Reset bridge: fifo_rst held for three cycles after release.
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("bridge_frst_c%0d", c), 32'(last_frst), 32'd1);
        end
        tick();
        check("bridge_first_grant", 32'(last_ready), 32'b0001);
        check("bridge_rr_ptr", 32'(dut.rr_ptr_q), 32'd1);

        // Fairness with concurrent pop: occupancy stays at one.
        for (int s = 0; s < 4; s++) begin
            tick();
            check($sformatf("fair_ready_%0d", s), 32'(last_ready), 32'(fair_seq[s]));
            check($sformatf("fair_occ_%0d", s), 32'(last_occ), 32'd1);
        end

        // Fill to full with the consumer stalled.
        cons_ready = 1'b0;
        repeat (3) tick();
        check("fill_occ", 32'(occupancy), 32'd4);

        // Full and no pop: attempt visible but blocked, pointer frozen.
        req_valid = 4'b0010;
        for (int s = 0; s < 5; s++) begin
            tick();
            check($sformatf("blk_pp_%0d", s), 32'(last_pp), 32'd1);
            check($sformatf("blk_push_%0d", s), 32'(last_push), 32'd0);
            check($sformatf("blk_ready_%0d", s), 32'(last_ready), 32'd0);
            check($sformatf("blk_rr_%0d", s), 32'(dut.rr_ptr_q), 32'd0);
        end

        // Full with same-cycle pop.
        cons_ready = 1'b1;
        req_valid  = 4'b0100;
        tick();
        check("fullpop_push", 32'(last_push), 32'd1);
        check("fullpop_pop", 32'(last_pop), 32'd1);
        check("fullpop_ready", 32'(last_ready), 32'b0100);
        check("fullpop_occ", 32'(occupancy), 32'd4);

        // Flush with three entries held.
        req_valid = '0;
        tick();
        check("pre_flush_occ", 32'(occupancy), 32'd3);
        flush_req = 1'b1;
        req_valid = 4'b1111;
        tick();
        check("flush_cycle_ready", 32'(last_ready), 32'd0);
        flush_req = 1'b0;
        for (int s = 0; s < 4; s++) begin
            tick();
            check($sformatf("drain_occ_%0d", s), 32'(last_occ), 32'(drain_occ[s]));
            check($sformatf("drain_busy_%0d", s), 32'(last_busy), 32'(drain_busy[s]));
            check($sformatf("drain_done_%0d", s), 32'(last_done), 32'(drain_done[s]));
            check($sformatf("drain_ready_%0d", s), 32'(last_ready), 32'd0);
        end
        tick();
        check("resume_done", 32'(last_done), 32'd0);
        check("resume_ready", 32'(last_ready), 32'b1000);

        // Reset asserted in the middle of a drain.
        cons_ready = 1'b0;
        repeat (2) tick();
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        tick();
        check("rstdrain_busy_before", 32'(last_busy), 32'd1);
        check("rstdrain_occ_before", 32'(last_occ), 32'd3);
        rst     = 1'b0;
        m_state = RUN;
        m_rr    = 0;
        m_occ   = 0;
        rel_cnt = 0;
        exp_q.delete();
        #1;
        check("rstdrain_busy", 32'(flush_busy), 32'd0);
        check("rstdrain_done", 32'(flush_done), 32'd0);
        check("rstdrain_occ", 32'(occupancy), 32'd0);
        check("rstdrain_frst", 32'(fif.fifo_rst), 32'd1);
        for (int s = 0; s < 2; s++) begin
            tick();
            check($sformatf("rstlow_done_%0d", s), 32'(last_done), 32'd0);
        end

        // Recovery after release.
        rst        = 1'b1;
        cons_ready = 1'b1;
        req_valid  = 4'b1010;
        repeat (3) tick();
        tick();
        check("recover_first_grant", 32'(last_ready), 32'b0010);
        repeat (4) tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/addr_entry_fifo_arbiter.md
# addr_entry_fifo_arbiter

Controller and round-robin arbiter for the shared address-entry FIFO. It arbitrates up to NUM_REQ producers onto the FIFO's single enqueue port and generates push, potential_push and data_in. It generates pop from a downstream valid/ready handshake, mirrors occupancy, and sequences a drain-and-flush protocol. It also supplies the FIFO's synchronous active-high reset and sits between the address producers and the FIFO instance, which it does not contain.

## Interface
- DATA_TYPE, logic: address-entry type carried through the FIFO.
- NUM_REQ, 4: number of producers, 2..8.
- FIFO_DEPTH, 4: depth of the attached FIFO; must equal that FIFO's FIFO_DEPTH parameter.

- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  producer i has an entry.
- req_data  in  NUM_REQ x DATA_TYPE  producer entries.
- req_ready  out  NUM_REQ  one-hot; entry i committed this cycle.
- fifo_rst  out  1  synchronous active-high reset to the FIFO.
- fifo_potential_push  out  1  FIFO data write enable.
- fifo_push  out  1  FIFO commit.
- fifo_data_in  out  DATA_TYPE  winner's entry.
- fifo_pop  out  1  FIFO dequeue.
- fifo_valid  in  1  FIFO non-empty.
- fifo_full  in  1  FIFO full.
- fifo_data_out  in  DATA_TYPE  FIFO head.
- cons_valid  out  1  head available to consumer.
- cons_data  out  DATA_TYPE  head entry.
- cons_ready  in  1  consumer accepts.
- flush_req  in  1  single-cycle request to drain.
- flush_busy  out  1  drain in progress.
- flush_done  out  1  one-cycle pulse when drained.
- occupancy  out  clog2(FIFO_DEPTH)+1  entries held.

## Operation
- **Reset bridge:** fifo_rst asserts asynchronously while rst=0. It deasserts synchronously on the third rising edge after rst rises (2-flop synchronizer plus hold). While fifo_rst=1, all grants, push and pop are 0.
- **States** (stored in a 2-bit state register):
  - RUN to DRAIN on flush_req.
  - DRAIN to DONE when occupancy==0 and fifo_pop=0.
  - DONE to RUN unconditionally.
  - flush_req is ignored outside RUN.
- **Grant enable:** grant_en = (state==RUN) & ~flush_req & ~fifo_rst. Requests arriving in the flush_req cycle are not granted.
- **Winner:** the first i with req_valid[i], searching rr_ptr, rr_ptr+1, … modulo NUM_REQ.
- **Push:**
  - fifo_potential_push = grant_en & |req_valid.
  - fifo_push = fifo_potential_push & (~fifo_full | fifo_pop).
  - fifo_data_in = req_data[winner].
  - req_ready = onehot(winner) & fifo_push.
- **Round-robin pointer:** rr_ptr becomes winner+1 (wrapping NUM_REQ-1 to 0) only on fifo_push. It is unchanged on a blocked attempt.
- **Pop:**
  - fifo_pop = fifo_valid & cons_ready & ~fifo_rst.
  - cons_valid = fifo_valid.
  - cons_data = fifo_data_out.
  - Popping continues in every state.
- **Occupancy:**
  - Next value is occupancy + fifo_push − fifo_pop, using FIFO-depth-width arithmetic that never exceeds FIFO_DEPTH and never goes below 0.
  - Simultaneous push and pop leaves it unchanged.
  - Push while full is allowed only with a same-cycle pop.
- **Status outputs:** flush_busy = (state==DRAIN); flush_done = (state==DONE).
- **Reset values:** state RUN, rr_ptr 0, occupancy 0, flush_busy 0, flush_done 0, fifo_rst 1. All combinational outputs are 0 while fifo_rst=1.
- **Reset mid-operation:** asserting rst during DRAIN returns the block to RUN with occupancy 0. No flush_done is issued.

## Timing
- Grant, push and data selection are combinational in the request cycle: zero-cycle latency to commit.
- The FIFO head is visible on cons_data in the cycle after the push, or later.
- Flush with an empty FIFO: flush_req at cycle N, DRAIN at N+1, DONE (flush_done=1) at N+2, RUN at N+3.
- occupancy and the registered state update on the rising edge following the event.
- Assertions:
  - fifo_full == (occupancy==FIFO_DEPTH).
  - fifo_valid == (occupancy!=0).
  - $onehot0(req_ready).
  - No fifo_push outside RUN.

## Structure
- The shared package holds the state enum (RUN, DRAIN, DONE) and a function computing the occupancy width from FIFO_DEPTH.
- One sub-module, addr_entry_rr_picker: combinational rotating-priority picker. Inputs are req_valid and rr_ptr; outputs are winner index, one-hot and any.
- The top-level module holds the state machine, rr_ptr, occupancy counter and reset bridge.

## Test plan
- **Reset bridge:** rst low then high at cycle 0 with req_valid=4'b1111 → fifo_rst=1 through cycle 2, first req_ready=4'b0001 at cycle 3, rr_ptr=1 afterwards.
- **Fairness:** req_valid=4'b1111 held, cons_ready=1, FIFO_DEPTH=4 → req_ready sequence 0001, 0010, 0100, 1000, 0001; occupancy stays at 1.
- **Full with pop:** fill to occupancy=4 with cons_ready=0, then cons_ready=1 with req_valid[2]=1 → fifo_push and fifo_pop same cycle, req_ready=4'b0100, occupancy stays 4.
- **Full blocked:** occupancy=4, cons_ready=0, req_valid=4'b0010 → fifo_potential_push=1, fifo_push=0, req_ready=0, rr_ptr unchanged for 5 cycles.
- **Flush with entries:** occupancy=3, flush_req pulse, cons_ready=1 → no grants, occupancy 3→2→1→0, flush_done one-cycle pulse two cycles after the last pop, grants resume next cycle.
- **Reset during drain:** rst=0 during DRAIN → flush_busy=0 immediately, no flush_done, occupancy=0.
